// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage feeding the control decoder. Owns the PC, drives a
//   synchronous-read instruction memory, and presents a registered
//   instruction word with its PC and an 8-bit control code. Handles stall,
//   downstream branch/jump redirect, and HALT detection.
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   stall          in   downstream not ready, hold the stage
//   branch_taken   in   redirect fetch to branch_target (wins over stall)
//   branch_target  in   redirect address, bit 0 ignored
//   imem_en        out  memory read enable (combinational)
//   imem_addr      out  memory read address (combinational)
//   imem_rdata     in   word for the address issued the previous enabled cycle
//   instr          out  registered instruction word
//   instr_pc       out  PC of instr
//   instr_valid    out  instr / instr_pc / ctrl_code valid
//   ctrl_code      out  {instr[15:12], instr[3:0]} (combinational from instr)
//   halted         out  HALT seen, fetch stopped until reset
// ---------------------------------------------------------------------------
module instruction_fetch #(
    parameter int unsigned        ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int unsigned        PC_STEP  = 2,
    parameter logic [3:0]         HALT_OP  = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic [7:0]        ctrl_code,
    output logic              halted
);

    localparam int unsigned INSTR_W = 16;
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(1);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  rd_pc_q, rd_pc_d;
    logic               rd_valid_q, rd_valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               instr_valid_q, instr_valid_d;

    logic [ADDR_W-1:0]  target_c;
    logic               redirect_c;
    logic               advance_c;
    logic               halt_hit_c;

    // Cycle classification shared by the FSM and the datapath.
    always_comb begin
        target_c   = branch_target & ALIGN_MASK;
        redirect_c = !rst && (state_q == S_RUN) && branch_taken;
        advance_c  = !rst && (state_q == S_RUN) && !branch_taken && !stall;
        // A HALT word only counts when it is a real word, not a stale rdata.
        halt_hit_c = advance_c && rd_valid_q && (imem_rdata[15:12] == HALT_OP);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: HALT is left only through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (halt_hit_c) state_d = S_HALT;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RUN;
        endcase
    end

    // FSM outputs: memory request and halted flag.
    always_comb begin
        imem_en   = redirect_c || advance_c;
        imem_addr = redirect_c ? target_c : fetch_pc_q;
        halted    = (state_q == S_HALT);
    end

    // Datapath next values: redirect flushes, stall holds, normal cycle shifts.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rd_pc_d       = rd_pc_q;
        rd_valid_d    = rd_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        if (redirect_c) begin
            fetch_pc_d    = target_c + STEP;
            rd_pc_d       = target_c;
            rd_valid_d    = 1'b1;
            instr_valid_d = 1'b0;
        end else if (advance_c) begin
            fetch_pc_d    = fetch_pc_q + STEP;
            rd_pc_d       = fetch_pc_q;
            rd_valid_d    = 1'b1;
            instr_d       = imem_rdata;
            instr_pc_d    = rd_pc_q;
            instr_valid_d = rd_valid_q;
        end else if (state_q == S_HALT) begin
            // Drop the word in flight; the HALT word stays until downstream takes it.
            rd_valid_d = 1'b0;
            if (!stall) begin
                instr_valid_d = 1'b0;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            rd_pc_q       <= '0;
            rd_valid_q    <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rd_pc_q       <= rd_pc_d;
            rd_valid_q    <= rd_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign ctrl_code   = {instr_q[15:12], instr_q[3:0]};

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//   Directed vector table, a wrapped-PC instance, and randomized traffic
//   compared against a transaction-level fetch model.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (RESET_PC = 0)
    logic        rst = 1'b1, stall = 1'b0, branch_taken = 1'b0;
    logic [15:0] branch_target = '0;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = '0;
    logic [15:0] instr, instr_pc;
    logic        instr_valid, halted;
    logic [7:0]  ctrl_code;

    // Wrap instance (RESET_PC = FFFE)
    logic        rst_b = 1'b1, stall_b = 1'b0, branch_taken_b = 1'b0;
    logic [15:0] branch_target_b = '0;
    logic        imem_en_b;
    logic [15:0] imem_addr_b;
    logic [15:0] imem_rdata_b = '0;
    logic [15:0] instr_b, instr_pc_b;
    logic        instr_valid_b, halted_b;
    logic [7:0]  ctrl_code_b;

    instruction_fetch u_dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .ctrl_code(ctrl_code), .halted(halted)
    );

    instruction_fetch #(.RESET_PC(16'hFFFE)) u_dut_wrap (
        .clk(clk), .rst(rst_b), .stall(stall_b), .branch_taken(branch_taken_b),
        .branch_target(branch_target_b), .imem_en(imem_en_b), .imem_addr(imem_addr_b),
        .imem_rdata(imem_rdata_b), .instr(instr_b), .instr_pc(instr_pc_b),
        .instr_valid(instr_valid_b), .ctrl_code(ctrl_code_b), .halted(halted_b)
    );

    // Synchronous-read memories; output holds when not enabled.
    logic [15:0] mem [0:32767];
    always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr[15:1]];

    function automatic logic [15:0] word_b(input logic [15:0] a);
        case (a)
            16'hFFFE: word_b = 16'hABCD;
            16'h0000: word_b = 16'h1357;
            16'h0002: word_b = 16'h2468;
            default:  word_b = 16'h0BAD;
        endcase
    endfunction
    always @(posedge clk) if (imem_en_b) imem_rdata_b <= word_b(imem_addr_b);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the next address to request, the queue of words
    // requested but not yet presented, and the presented word.
    logic [15:0] m_next  = '0;
    logic [15:0] m_fly[$];
    logic        m_v     = 1'b0;
    logic [15:0] m_pc    = '0;
    logic [15:0] m_word  = '0;
    logic        m_halt  = 1'b0;

    function automatic logic m_exp_en();
        return !rst && !m_halt && (branch_taken || !stall);
    endfunction

    function automatic logic [15:0] m_exp_addr();
        return branch_taken ? (branch_target & 16'hFFFE) : m_next;
    endfunction

    task automatic model_step();
        logic [15:0] a;
        if (rst) begin
            m_next = 16'h0000; m_fly.delete(); m_v = 1'b0; m_pc = '0; m_word = '0; m_halt = 1'b0;
        end else if (m_halt) begin
            m_fly.delete();
            if (!stall) m_v = 1'b0;
        end else if (branch_taken) begin
            a = branch_target & 16'hFFFE;
            m_fly.delete();
            m_fly.push_back(a);
            m_next = a + 16'd2;
            m_v = 1'b0;
        end else if (!stall) begin
            if (m_fly.size() > 0) begin
                a = m_fly.pop_front();
                m_v = 1'b1; m_pc = a; m_word = mem[a[15:1]];
                if (m_word[15:12] == 4'hF) m_halt = 1'b1;
            end else begin
                m_v = 1'b0;
            end
            m_fly.push_back(m_next);
            m_next = m_next + 16'd2;
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic b, input logic [15:0] t);
        rst = r; stall = s; branch_taken = b; branch_target = t;
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    typedef struct {
        logic        r, s, b;
        logic [15:0] t;
        logic        en;
        logic [15:0] addr;
        logic        v;
        logic [15:0] ins, pc;
        logic [7:0]  ctrl;
        logic        h;
        logic        cd;
    } vec_t;

    function automatic vec_t mk(input logic r, s, b, input logic [15:0] t,
                                input logic en, input logic [15:0] addr, input logic v,
                                input logic [15:0] ins, pc, input logic [7:0] ctrl,
                                input logic h, cd);
        vec_t x;
        x.r = r; x.s = s; x.b = b; x.t = t; x.en = en; x.addr = addr; x.v = v;
        x.ins = ins; x.pc = pc; x.ctrl = ctrl; x.h = h; x.cd = cd;
        return x;
    endfunction

    vec_t tbl[$];

    initial begin
        logic        e_en;
        logic [15:0] e_addr;
        logic [15:0] w;

        for (int i = 0; i < 32768; i++) mem[i] = '0;
        mem[0] = 16'h1234; mem[1] = 16'h5AFC; mem[2] = 16'h3A47; mem[3] = 16'h6B58;
        mem[4] = 16'hF000; mem[5] = 16'h7777; mem[16'h20] = 16'h4C21; mem[16'h21] = 16'h8D32;

        // r s b  tgt      en addr     v  instr     pc       ctrl   h  cd
        tbl.push_back(mk(1,0,0,16'h0,    0,16'h0,   0,16'h0,   16'h0,  8'h00, 0,1)); // reset
        tbl.push_back(mk(1,0,0,16'h0,    0,16'h0,   0,16'h0,   16'h0,  8'h00, 0,1));
        tbl.push_back(mk(0,0,0,16'h0,    1,16'h0,   0,16'h0,   16'h0,  8'h00, 0,0)); // first fetch
        tbl.push_back(mk(0,0,0,16'h0,    1,16'h2,   1,16'h1234,16'h0,  8'h14, 0,1));
        tbl.push_back(mk(0,0,0,16'h0,    1,16'h4,   1,16'h5AFC,16'h2,  8'h5C, 0,1));
        tbl.push_back(mk(0,0,0,16'h0,    1,16'h6,   1,16'h3A47,16'h4,  8'h37, 0,1));
        tbl.push_back(mk(0,1,0,16'h0,    0,16'h0,   1,16'h3A47,16'h4,  8'h37, 0,1)); // stall x3
        tbl.push_back(mk(0,1,0,16'h0,    0,16'h0,   1,16'h3A47,16'h4,  8'h37, 0,1));
        tbl.push_back(mk(0,1,0,16'h0,    0,16'h0,   1,16'h3A47,16'h4,  8'h37, 0,1));
        tbl.push_back(mk(0,0,0,16'h0,    1,16'h8,   1,16'h6B58,16'h6,  8'h68, 0,1));
        tbl.push_back(mk(0,0,0,16'h0,    1,16'hA,   1,16'hF000,16'h8,  8'hF0, 1,1)); // HALT word
        tbl.push_back(mk(0,0,1,16'h40,   0,16'h0,   0,16'h0,   16'h0,  8'h00, 1,0)); // branch ignored
        tbl.push_back(mk(0,0,1,16'h40,   0,16'h0,   0,16'h0,   16'h0,  8'h00, 1,0));
        tbl.push_back(mk(1,0,0,16'h0,    0,16'h0,   0,16'h0,   16'h0,  8'h00, 0,1)); // reset in HALT
        tbl.push_back(mk(0,0,0,16'h0,    1,16'h0,   0,16'h0,   16'h0,  8'h00, 0,0));
        tbl.push_back(mk(0,0,0,16'h0,    1,16'h2,   1,16'h1234,16'h0,  8'h14, 0,1));
        tbl.push_back(mk(0,1,1,16'h41,   1,16'h40,  0,16'h0,   16'h0,  8'h00, 0,0)); // branch+stall
        tbl.push_back(mk(0,0,0,16'h0,    1,16'h42,  1,16'h4C21,16'h40, 8'h41, 0,1));
        tbl.push_back(mk(0,0,0,16'h0,    1,16'h44,  1,16'h8D32,16'h42, 8'h82, 0,1));
        tbl.push_back(mk(0,1,0,16'h0,    0,16'h0,   1,16'h8D32,16'h42, 8'h82, 0,1));
        tbl.push_back(mk(1,1,0,16'h0,    0,16'h0,   0,16'h0,   16'h0,  8'h00, 0,1)); // reset mid-stall
        tbl.push_back(mk(0,0,0,16'h0,    1,16'h0,   0,16'h0,   16'h0,  8'h00, 0,0));
        tbl.push_back(mk(0,0,0,16'h0,    1,16'h2,   1,16'h1234,16'h0,  8'h14, 0,1));

        @(negedge clk);
        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].s, tbl[i].b, tbl[i].t);
            chk($sformatf("t%0d_en", i), 32'(imem_en), 32'(tbl[i].en));
            if (tbl[i].en) chk($sformatf("t%0d_addr", i), 32'(imem_addr), 32'(tbl[i].addr));
            adv();
            chk($sformatf("t%0d_valid", i), 32'(instr_valid), 32'(tbl[i].v));
            chk($sformatf("t%0d_halted", i), 32'(halted), 32'(tbl[i].h));
            if (tbl[i].cd) begin
                chk($sformatf("t%0d_instr", i), 32'(instr), 32'(tbl[i].ins));
                chk($sformatf("t%0d_pc", i), 32'(instr_pc), 32'(tbl[i].pc));
                chk($sformatf("t%0d_ctrl", i), 32'(ctrl_code), 32'(tbl[i].ctrl));
            end
        end

        // Wrap instance: FFFE then 0000 then 0002.
        rst_b = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("wrap_rst_valid", 32'(instr_valid_b), 32'd0);
        chk("wrap_rst_ctrl", 32'(ctrl_code_b), 32'd0);
        rst_b = 1'b0; #1;
        chk("wrap_addr0", 32'(imem_addr_b), 32'hFFFE);
        chk("wrap_en0", 32'(imem_en_b), 32'd1);
        @(posedge clk); @(negedge clk);
        chk("wrap_valid0", 32'(instr_valid_b), 32'd0);
        #1 chk("wrap_addr1", 32'(imem_addr_b), 32'h0000);
        @(posedge clk); @(negedge clk);
        chk("wrap_instr1", 32'(instr_b), 32'hABCD);
        chk("wrap_pc1", 32'(instr_pc_b), 32'hFFFE);
        chk("wrap_ctrl1", 32'(ctrl_code_b), 32'hAD);
        #1 chk("wrap_addr2", 32'(imem_addr_b), 32'h0002);
        @(posedge clk); @(negedge clk);
        chk("wrap_instr2", 32'(instr_b), 32'h1357);
        chk("wrap_pc2", 32'(instr_pc_b), 32'h0000);
        chk("wrap_valid2", 32'(instr_valid_b), 32'd1);
        @(posedge clk); @(negedge clk);
        chk("wrap_pc3", 32'(instr_pc_b), 32'h0002);
        rst_b = 1'b1;

        // Randomized traffic against the model; HALT words kept rare.
        for (int i = 0; i < 32768; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hF && $urandom_range(0, 3) != 0) w[15:12] = 4'h0;
            mem[i] = w;
        end
        drive(1, 0, 0, '0); adv();
        drive(1, 0, 0, '0); adv();
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0), 16'($urandom));
            e_en   = m_exp_en();
            e_addr = m_exp_addr();
            chk("rnd_en", 32'(imem_en), 32'(e_en));
            if (e_en) chk("rnd_addr", 32'(imem_addr), 32'(e_addr));
            adv();
            chk("rnd_valid", 32'(instr_valid), 32'(m_v));
            chk("rnd_halted", 32'(halted), 32'(m_halt));
            if (m_v) begin
                chk("rnd_instr", 32'(instr), 32'(m_word));
                chk("rnd_pc", 32'(instr_pc), 32'(m_pc));
                chk("rnd_ctrl", 32'(ctrl_code), 32'({m_word[15:12], m_word[3:0]}));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
